// File: rtl/updown_mod_counter_pkg.sv
// -----------------------------------------------------------------------------
// updown_counter_pkg
// Shared encodings for the up/down modulus counter: the direction and
// limit-mode values carried on up_dn and sat.
// No ports (package).
// -----------------------------------------------------------------------------
package updown_counter_pkg;

   // Direction select carried on up_dn
   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;

   // Limit behaviour carried on sat
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

endpackage : updown_counter_pkg

// File: rtl/updown_mod_counter_if.sv
// -----------------------------------------------------------------------------
// updown_mod_counter_if
// Bundles the control inputs and the count/flag outputs of the counter.
//   master modport : drives en, clr, load, load_val, up_dn, sat, modulus,
//                    prescale; observes count, tc, ovf
//   slave modport  : the counter side (inverse directions)
// clk and rst are not part of the bundle.
// -----------------------------------------------------------------------------
interface updown_mod_counter_if #(
   parameter int WIDTH = 32,
   parameter int PS_W  = 8
);

   logic             en;
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             up_dn;
   logic             sat;
   logic [WIDTH-1:0] modulus;
   logic [PS_W-1:0]  prescale;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             ovf;

   modport master (
      output en, clr, load, load_val, up_dn, sat, modulus, prescale,
      input  count, tc, ovf
   );

   modport slave (
      input  en, clr, load, load_val, up_dn, sat, modulus, prescale,
      output count, tc, ovf
   );

endinterface : updown_mod_counter_if

// File: rtl/updown_mod_counter_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides the enabled-cycle stream so that one tick is produced every
// prescale+1 enabled cycles.
//   clk      in  clock
//   rst      in  asynchronous active-high reset
//   en       in  count enable; the divider holds while low
//   restart  in  synchronous restart of the divider (clear or load)
//   prescale in  PS_W divide value minus one
//   tick     out combinational step request for the current cycle
// -----------------------------------------------------------------------------
module tick_prescaler #(
   parameter int PS_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            restart,
   input  logic [PS_W-1:0] prescale,
   output logic            tick
);

   logic [PS_W-1:0] ps;

   // Using >= rather than == lets a lowered prescale take effect at once
   // instead of running the divider all the way round.
   assign tick = en && (ps >= prescale);

   // Divider register: restart wins over counting, en low freezes it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ps <= '0;
      end else if (restart) begin
         ps <= '0;
      end else if (en) begin
         if (tick) begin
            ps <= '0;
         end else begin
            ps <= ps + 1'b1;
         end
      end
   end

endmodule : tick_prescaler

// File: rtl/updown_mod_counter.sv
// -----------------------------------------------------------------------------
// updown_mod_counter
// Up/down counter over the range 0..modulus with wrap or saturate at the
// limits, synchronous clear/load, prescaled enable and terminal-count flags.
//   clk  in  clock
//   rst  in  asynchronous active-high reset
//   bus  slave modport of updown_mod_counter_if:
//        en, clr, load, load_val, up_dn, sat, modulus, prescale in;
//        count (registered), tc (one-cycle pulse), ovf (sticky) out
// -----------------------------------------------------------------------------
module updown_mod_counter
   import updown_counter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int PS_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   updown_mod_counter_if.slave  bus
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] next_count;
   logic             tc_q;
   logic             ovf_q;
   logic             tick;
   logic             limit;
   logic             restart;

   // Clear and load both realign the divider so the first step after them
   // lands on the (prescale+1)th enabled edge.
   assign restart = bus.clr | bus.load;

   tick_prescaler #(
      .PS_W (PS_W)
   ) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.en),
      .restart  (restart),
      .prescale (bus.prescale),
      .tick     (tick)
   );

   // Next-count selection for a step. Going up, any count at or above the
   // modulus is a limit (covers values loaded above the range). Going down,
   // only zero is a limit, so an out-of-range count walks back into range.
   always_comb begin
      next_count = count_q;
      limit      = 1'b0;
      if (tick) begin
         if (bus.up_dn == DIR_UP) begin
            if (count_q >= bus.modulus) begin
               limit      = 1'b1;
               next_count = (bus.sat == MODE_SAT) ? count_q : '0;
            end else begin
               next_count = count_q + 1'b1;
            end
         end else begin
            if (count_q == '0) begin
               limit      = 1'b1;
               next_count = (bus.sat == MODE_SAT) ? '0 : bus.modulus;
            end else begin
               next_count = count_q - 1'b1;
            end
         end
      end
   end

   // State registers: clear beats load beats step; tc only reflects a limit
   // reached by a step this edge, ovf latches until reset or clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (bus.clr) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (bus.load) begin
         count_q <= bus.load_val;
         tc_q    <= 1'b0;
      end else begin
         count_q <= next_count;
         tc_q    <= limit;
         ovf_q   <= ovf_q | limit;
      end
   end

   assign bus.count = count_q;
   assign bus.tc    = tc_q;
   assign bus.ovf   = ovf_q;

endmodule : updown_mod_counter

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised up/down counter with programmable modulus, wrap-or-saturate mode, synchronous load and clear, clock-enable prescaler and terminal-count signalling. It generalises the plain 32-bit free-running counter and serves as the standard timebase/event counter for downstream blocks (timers, PWM, baud generators).

## Interface
- WIDTH, 32, counter width in bits (min 2)
- PS_W, 8, prescaler width in bits (min 1)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  count enable; gates the prescaler
- clr  in  1  synchronous clear
- load  in  1  synchronous load
- load_val  in  WIDTH  value written on load
- up_dn  in  1  direction: 1 = up, 0 = down
- sat  in  1  limit mode: 1 = saturate, 0 = wrap
- modulus  in  WIDTH  upper limit; count range 0..modulus
- prescale  in  PS_W  one step every prescale+1 enabled cycles
- count  out  WIDTH  current count, registered
- tc  out  1  terminal-count pulse, registered, one cycle
- ovf  out  1  sticky limit-reached flag

## Operation
- Priority per edge: rst (async) > clr > load > step > hold.
- rst: count=0, tc=0, ovf=0, prescaler=0, immediately on assertion.
- clr: count=0, tc=0, ovf=0, prescaler=0.
- load: count=load_val (any value, may exceed modulus), tc=0, prescaler=0; ovf unchanged.
- Prescaler ps: if en=0, holds. If en=1: ps>=prescale -> tick=1, ps=0; else ps=ps+1. prescale=0 -> tick every enabled cycle.
- Step (tick=1), up: count>=modulus -> limit event; next = sat ? count : 0. Otherwise count+1.
- Step, down: count==0 -> limit event; next = sat ? 0 : modulus. Otherwise count-1 (counts back into range if count>modulus).
- Limit event: tc=1 on the next cycle only; ovf set, held until rst or clr.
- Non-limit cycles, including clr/load cycles: tc=0.
- modulus=0: up and down both hit limit every tick; count stays 0; tc pulses every tick.
- All arithmetic modulo 2^WIDTH; no carry output. modulus=2^WIDTH-1, wrap mode, reproduces a free-running counter.
- up_dn, sat, modulus and prescale may change any cycle; they take effect on the next tick decision, with no flush.

## Timing
- count updates on the edge where tick=1; no extra pipeline latency.
- First tick after rst/clr/load: on the (prescale+1)th enabled edge.
- tc and ovf assert on the same edge that applies the limit-event count value.
- tc is never high for two consecutive cycles unless limit events occur on consecutive ticks (prescale=0).
- rst deasserts synchronously to clk externally; the block places no other constraint on it.

## Structure
- Package updown_counter_pkg: DIR_UP=1'b1, DIR_DOWN=1'b0, MODE_WRAP=1'b0, MODE_SAT=1'b1.
- Sub-module tick_prescaler (PS_W; clk, rst, en, restart, prescale -> tick). restart is driven by clr|load.
- The top holds the count register, next-count mux, tc and ovf registers.

## Test plan
- Reset: assert rst mid-count at count=17 -> count=0, tc=0, ovf=0 without a clock edge; after release with en=1, prescale=0, up: count 1,2,3 on successive edges.
- Up wrap: modulus=5, sat=0, prescale=0 -> 0..5,0; tc high the cycle count shows 0 after 5; ovf=1 and held.
- Down saturate: load 3, up_dn=0, sat=1 -> 2,1,0,0,0; tc pulses on each tick at 0; then clr -> ovf=0.
- Prescale: prescale=3, en=1 -> count increments every 4th edge; en low for 2 cycles mid-period stretches the period to 6 edges.
- Load above modulus: modulus=10, load 20, up, wrap -> next tick count=0 with tc; down from 20 -> 19,18,...
- Priority: clr, load and a tick in the same cycle -> count=0, prescaler restarted; load and a tick together -> count=load_val, no step.
